// File: rtl/vga_btn_pkg.sv
// Shared encodings for the button conditioner: move directions, debounce FSM states, button indices.
// The BTN_AUTOREPEAT_EN build uses max_int to size its repeat counter.
package vga_btn_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int BTN_U    = 0;
    localparam int BTN_D    = 1;
    localparam int BTN_L    = 2;
    localparam int BTN_R    = 3;
    localparam int NUM_BTNS = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Lowest set bit wins, so UP beats DOWN beats LEFT beats RIGHT.
    function automatic dir_e pick_dir(input logic [NUM_BTNS-1:0] p);
        if (p[BTN_U]) return DIR_UP;
        if (p[BTN_D]) return DIR_DOWN;
        if (p[BTN_L]) return DIR_LEFT;
        return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: two-flop synchroniser, debounce FSM, one-cycle press pulse.
// With BTN_AUTOREPEAT_EN defined, a held button also emits repeat pulses.
module btn_debounce_fsm
    import vga_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1485000,
    parameter int REPEAT_DELAY    = 74250000,
    parameter int REPEAT_PERIOD   = 14850000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    btn_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pulse_reg, pulse_next;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    logic [RCNT_W-1:0] rcnt_reg, rcnt_next;
    logic              rep_phase_reg, rep_phase_next;
    logic [RCNT_W-1:0] rep_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_reg      <= '0;
            rep_phase_reg <= 1'b0;
`endif
        end else begin
            s1_reg    <= btn_raw;
            s2_reg    <= s1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_reg      <= rcnt_next;
            rep_phase_reg <= rep_phase_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rcnt_next      = rcnt_reg;
        rep_phase_next = rep_phase_reg;
        // First repeat waits the long delay, later ones the short period.
        rep_last       = rep_phase_reg ? RCNT_W'(REPEAT_PERIOD - 1) : RCNT_W'(REPEAT_DELAY - 1);
`endif
        case (state_reg)
            IDLE: begin
                if (s2_reg) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HELD;
                    pulse_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    rcnt_next      = '0;
                    rep_phase_next = 1'b0;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!s2_reg) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (rcnt_reg == rep_last) begin
                    pulse_next     = 1'b1;
                    rcnt_next      = '0;
                    rep_phase_next = 1'b1;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed returns to HELD silently; rcnt stays frozen.
                if (s2_reg) begin
                    state_next = HELD;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign btn_level = (state_reg == HELD) || (state_reg == RELEASE_WAIT);
    assign btn_pulse = pulse_reg;

endmodule

// File: rtl/vga_btn_conditioner.sv
// Four debounced buttons feeding a registered U>D>L>R move arbiter.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat pulses on held buttons.
module vga_btn_conditioner
    import vga_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1485000,
    parameter int REPEAT_DELAY    = 74250000,
    parameter int REPEAT_PERIOD   = 14850000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_pulse,
    output logic                move_valid,
    output logic [1:0]          move_dir
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce_fsm #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_fsm (
                .clk      (clk),
                .rst      (rst),
                .btn_raw  (btn_raw[gi]),
                .btn_level(btn_level[gi]),
                .btn_pulse(btn_pulse[gi])
            );
        end
    endgenerate

    logic move_valid_reg;
    dir_e move_dir_reg;

    // Losing pulses in the same cycle are dropped, never queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_valid_reg <= 1'b0;
            move_dir_reg   <= DIR_UP;
        end else begin
            move_valid_reg <= |btn_pulse;
            if (|btn_pulse) begin
                move_dir_reg <= pick_dir(btn_pulse);
            end
        end
    end

    assign move_valid = move_valid_reg;
    assign move_dir   = move_dir_reg;

endmodule
